// File: rtl/chip8_alu_mc_if.sv
// Request/response bundle for the chip8_alu_mc ALU: start/op/operands in,
// ready/done/result/flag/bcd out.
interface chip8_alu_mc_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [3:0]            op;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  ready;
  logic                  done;
  logic [WIDTH-1:0]      result;
  logic                  flag;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, op, a, b,
    input  ready, done, result, flag, bcd
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result, flag, bcd
  );
endinterface

// File: rtl/chip8_alu_mc.sv
// CHIP-8 style ALU: single-cycle logic/arithmetic ops plus a multi-cycle
// double-dabble binary-to-BCD conversion (one bit per clock).
module chip8_alu_mc #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  chip8_alu_mc_if.slave   bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 8 || WIDTH > 16) begin : g_bad_width
    $error("chip8_alu_mc: WIDTH must be in 8..16");
  end
  if ((10 ** DIGITS) <= ((2 ** WIDTH) - 1)) begin : g_bad_digits
    $error("chip8_alu_mc: DIGITS too small to hold 2^WIDTH-1");
  end

  typedef enum logic [3:0] {
    OP_MOV  = 4'h0, OP_OR  = 4'h1, OP_AND = 4'h2, OP_XOR = 4'h3,
    OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_SHR = 4'h6, OP_SUBN = 4'h7,
    OP_EQ   = 4'h8, OP_GT  = 4'h9, OP_INC = 4'hA, OP_BCD = 4'hB,
    OP_SHL  = 4'hE
  } op_e;

  typedef enum logic {S_IDLE, S_CONV} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    dig_q,   dig_d;
  logic [BW-1:0]    bcd_q,   bcd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q,  flag_d;
  logic             done_q,  done_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;
  logic [BW-1:0]    dig_adj;
  logic [BW-1:0]    dig_next;
  op_e              op;

  assign op = op_e'(bus.op);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    case (op)
      OP_MOV:  alu_res = bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_ADD:  {alu_flag, alu_res} = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB:  begin alu_res = bus.a - bus.b; alu_flag = (bus.a >= bus.b); end
      OP_SHR:  begin alu_res = bus.a >> 1;    alu_flag = bus.a[0];         end
      OP_SUBN: begin alu_res = bus.b - bus.a; alu_flag = (bus.b >= bus.a); end
      OP_EQ:   alu_res = WIDTH'(bus.a == bus.b);
      OP_GT:   alu_res = WIDTH'(bus.a > bus.b);
      OP_INC:  begin alu_res = bus.a + WIDTH'(1); alu_flag = &bus.a; end
      OP_SHL:  begin alu_res = bus.a << 1; alu_flag = bus.a[WIDTH-1]; end
      default: ;  // BCD is handled by the FSM; C, D, F complete as zero
    endcase
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    dig_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_adj[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3
                                                     : dig_q[4*i +: 4];
    end
  end

  assign dig_next = {dig_adj[BW-2:0], shift_q[WIDTH-1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    dig_d    = dig_q;
    bcd_d    = bcd_q;
    result_d = result_q;
    flag_d   = flag_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op == OP_BCD) begin
            state_d = S_CONV;
            shift_d = bus.a;
            dig_d   = '0;
            cnt_d   = '0;
          end else begin
            result_d = alu_res;
            flag_d   = alu_flag;
            done_d   = 1'b1;
          end
        end
      end
      S_CONV: begin
        dig_d   = dig_next;
        shift_d = shift_q << 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Digits only reach bcd here, so partial conversions never show.
          state_d = S_IDLE;
          cnt_d   = '0;
          bcd_d   = dig_next;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      dig_q    <= '0;
      bcd_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      dig_q    <= dig_d;
      bcd_q    <= bcd_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag   = flag_q;
  assign bus.bcd    = bcd_q;
endmodule

// File: tb/tb_chip8_alu_mc.sv
// Self-checking bench for chip8_alu_mc (WIDTH=8, DIGITS=3): vector table,
// scoreboard-checked done pulses, and hand sequences for BCD and reset.
module tb_chip8_alu_mc;
  logic clk;
  logic reset_n;

  chip8_alu_mc_if #(.WIDTH(8), .DIGITS(3)) bus ();

  chip8_alu_mc #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       flag;
  } vec_t;

  typedef struct {
    logic [7:0]  res;
    logic        flag;
    logic [11:0] bcd;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vecs[$];

  logic [7:0]  model_res  = '0;
  logic        model_flag = 1'b0;
  logic [11:0] model_bcd  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", 32'(bus.result), 32'(e.res));
        check("sb_flag",   32'(bus.flag),   32'(e.flag));
        check("sb_bcd",    32'(bus.bcd),    32'(e.bcd));
      end
    end
  end

  function automatic void ref_alu(input logic [3:0] op, input int a, input int b,
                                  output logic [7:0] res, output logic flag);
    int r;
    r = 0;
    flag = 1'b0;
    case (op)
      4'h0: r = b;
      4'h1: r = a | b;
      4'h2: r = a & b;
      4'h3: r = a ^ b;
      4'h4: begin r = (a + b) % 256; flag = (a + b) > 255; end
      4'h5: begin r = (a - b + 256) % 256; flag = a >= b; end
      4'h6: begin r = a / 2; flag = (a % 2) == 1; end
      4'h7: begin r = (b - a + 256) % 256; flag = b >= a; end
      4'h8: r = (a == b) ? 1 : 0;
      4'h9: r = (a > b) ? 1 : 0;
      4'hA: begin r = (a + 1) % 256; flag = (a == 255); end
      4'hE: begin r = (a * 2) % 256; flag = (a >= 128); end
      default: r = 0;
    endcase
    res = 8'(r);
  endfunction

  function automatic logic [11:0] ref_bcd(input int a);
    return {4'(a / 100), 4'((a / 10) % 10), 4'(a % 10)};
  endfunction

  // Drives one request for a single cycle; pushes expectation only if accepted.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_res, input logic exp_flag);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (bus.ready === 1'b1) begin
      if (op == 4'hB) begin
        model_bcd = ref_bcd(int'(a));
      end else begin
        model_res  = exp_res;
        model_flag = exp_flag;
      end
      sb.push_back('{res: model_res, flag: model_flag, bcd: model_bcd});
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // BCD request; ready must stay low for 8 cycles, then one done pulse.
  task automatic run_bcd(input logic [7:0] a, input bit try_add);
    issue(4'hB, a, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("conv_ready_low", 32'(bus.ready), 32'd0);
      if (try_add && i == 3) begin
        bus.start = 1'b1;
        bus.op    = 4'h4;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("conv_done", 32'(bus.done), 32'd1);
    check("conv_ready_back", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check("conv_done_single", 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    logic       f;
    logic [3:0] rop;
    logic [7:0] ra, rb;

    vecs.push_back('{4'h4, 8'hFF, 8'h01, 8'h00, 1'b1});
    vecs.push_back('{4'h4, 8'h12, 8'h34, 8'h46, 1'b0});
    vecs.push_back('{4'h5, 8'h10, 8'h20, 8'hF0, 1'b0});
    vecs.push_back('{4'h5, 8'h20, 8'h20, 8'h00, 1'b1});
    vecs.push_back('{4'h7, 8'h10, 8'h20, 8'h10, 1'b1});
    vecs.push_back('{4'hE, 8'h81, 8'h00, 8'h02, 1'b1});
    vecs.push_back('{4'h6, 8'h81, 8'h00, 8'h40, 1'b1});
    vecs.push_back('{4'hA, 8'hFF, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{4'hC, 8'h55, 8'hAA, 8'h00, 1'b0});
    vecs.push_back('{4'h0, 8'h11, 8'h5A, 8'h5A, 1'b0});
    vecs.push_back('{4'h1, 8'hF0, 8'h0F, 8'hFF, 1'b0});
    vecs.push_back('{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0});
    vecs.push_back('{4'h3, 8'hFF, 8'h0F, 8'hF0, 1'b0});
    vecs.push_back('{4'h8, 8'h33, 8'h33, 8'h01, 1'b0});
    vecs.push_back('{4'h8, 8'h33, 8'h34, 8'h00, 1'b0});
    vecs.push_back('{4'h9, 8'h80, 8'h7F, 8'h01, 1'b0});
    vecs.push_back('{4'h9, 8'h7F, 8'h80, 8'h00, 1'b0});
    vecs.push_back('{4'hA, 8'h7F, 8'h00, 8'h80, 1'b0});
    vecs.push_back('{4'h6, 8'h02, 8'h00, 8'h01, 1'b0});
    vecs.push_back('{4'hE, 8'h40, 8'h00, 8'h80, 1'b0});
    vecs.push_back('{4'hD, 8'hFF, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{4'h4, 8'h80, 8'h80, 8'h00, 1'b1});
    vecs.push_back('{4'hF, 8'h01, 8'h02, 8'h00, 1'b0});

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    #2;
    check("rst_ready",  32'(bus.ready),  32'd1);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flag",   32'(bus.flag),   32'd0);
    check("rst_bcd",    32'(bus.bcd),    32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table vectors issued back-to-back on consecutive edges.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flag);
      check("tbl_ready", 32'(bus.ready), 32'd1);
    end
    repeat (2) @(negedge clk);

    // Single-cycle latency: done exactly one cycle after accept.
    issue(4'h4, 8'hFF, 8'h01, 8'h00, 1'b1);
    @(negedge clk);
    check("lat_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("lat_done_low", 32'(bus.done), 32'd0);
    check("hold_flag", 32'(bus.flag), 32'd1);

    // BCD with an ignored ADD during conversion; result/flag must persist.
    run_bcd(8'hFF, 1'b1);
    check("bcd_ff", 32'(bus.bcd), 32'h255);
    check("bcd_ff_res", 32'(bus.result), 32'h00);
    check("bcd_ff_flag", 32'(bus.flag), 32'd1);
    run_bcd(8'h00, 1'b0);
    check("bcd_00", 32'(bus.bcd), 32'h000);
    run_bcd(8'h64, 1'b0);
    check("bcd_64", 32'(bus.bcd), 32'h100);

    // Reset during conversion aborts with no done pulse.
    issue(4'hB, 8'hC8, 8'h00, 8'h00, 1'b0);
    void'(sb.pop_back());
    model_bcd = 12'h100;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_ready",  32'(bus.ready),  32'd1);
    check("abort_done",   32'(bus.done),   32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flag",   32'(bus.flag),   32'd0);
    check("abort_bcd",    32'(bus.bcd),    32'd0);
    model_res  = '0;
    model_flag = 1'b0;
    model_bcd  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(bus.done), 32'd0);
    run_bcd(8'h09, 1'b0);
    check("bcd_09", 32'(bus.bcd), 32'h009);

    // Random mix of single-cycle ops and conversions against the model.
    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      if (rop == 4'hB) begin
        run_bcd(ra, 1'b0);
      end else begin
        ref_alu(rop, int'(ra), int'(rb), r, f);
        issue(rop, ra, rb, r, f);
      end
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chip8_alu_mc.md
CHIP8_ALU_MC -- requirements
Module: chip8_alu_mc

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; legal range 8..16.
REQ-002 Parameter: DIGITS, default 3, BCD digit count; legal only if 10^DIGITS > 2^WIDTH-1, otherwise elaboration shall fail.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only while ready=1.
REQ-006 op  input  4  operation code, per REQ-011.
REQ-007 a, b  input  WIDTH each  operands; sampled on the accepting edge only.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 done  output  1  one-cycle pulse; result, flag and bcd valid from this cycle on.
REQ-010 result  output WIDTH; flag  output 1; bcd  output 4*DIGITS, digit 0 in bits [3:0].

Function
REQ-011 The block shall implement these op codes (all arithmetic modulo 2^WIDTH):
- 0 MOV: result=b, flag=0.
- 1 OR, 2 AND, 3 XOR: bitwise, flag=0.
- 4 ADD: result=a+b, flag=carry out of bit WIDTH-1.
- 5 SUB: result=a-b, flag=(a>=b).
- 6 SHR: result=a>>1, flag=a[0].
- 7 SUBN: result=b-a, flag=(b>=a).
- 8 EQ: result=(a==b) zero-extended, flag=0.
- 9 GT: result=(a>b) zero-extended, unsigned, flag=0.
- A INC: result=a+1, flag=1 iff a is all ones.
- B BCD: multi-cycle conversion of a into bcd, per REQ-014..REQ-016.
- E SHL: result=a<<1, flag=a[WIDTH-1].
REQ-012 Single-cycle ops, start accepted at edge T: result and flag registered at T; done=1 in the cycle after T; ready stays 1 throughout.
REQ-013 Undefined op codes (C, D, F) shall complete like single-cycle ops with result=0 and flag=0.
REQ-014 FSM states: IDLE and CONV. IDLE->CONV on an accepted op B; CONV->IDLE after the WIDTH-th iteration; no other transitions except reset.
REQ-015 On accepting BCD at edge T: a is copied into an internal shift register, the internal digit register is cleared, and the iteration counter is set to 0.
- Each following edge in CONV performs one double-dabble iteration: every digit >=5 has 3 added, then the digit chain is shifted left by 1, taking in the shift-register MSB.
REQ-016 After the WIDTH-th iteration (edge T+WIDTH):
- the internal digits are copied to bcd and done pulses in the following cycle;
- result and flag are left unchanged;
- ready is low in the cycles after edges T..T+WIDTH-1.
REQ-017 bcd, result and flag shall hold their values between done pulses; internal conversion state shall never be visible on bcd before completion.
REQ-018 A start asserted while ready=0 shall be ignored: no queuing, no effect on the conversion in progress.
REQ-019 done shall never be high for two consecutive cycles from a single request. Back-to-back single-cycle requests on consecutive edges each produce their own done pulse.
REQ-020 flag, once written, shall not be cleared except by a later completed op or by reset.

Reset
REQ-021 While reset_n=0, asynchronously and regardless of clk:
- state=IDLE, counter=0, internal registers=0;
- result=0, flag=0, bcd=0, done=0, ready=1.
REQ-022 Reset asserted during CONV shall abort the conversion with no done pulse. After release, the first edge with start=1 is accepted normally.

Verification (WIDTH=8, DIGITS=3)
REQ-023 ADD a=0xFF b=0x01 -> result=0x00, flag=1, done 1 cycle after accept. ADD 0x12+0x34 -> 0x46, flag=0.
REQ-024 SUB 0x10-0x20 -> 0xF0, flag=0. SUB 0x20-0x20 -> 0x00, flag=1. SUBN a=0x10 b=0x20 -> 0x10, flag=1.
REQ-025 SHL a=0x81 -> 0x02, flag=1. SHR a=0x81 -> 0x40, flag=1. INC a=0xFF -> 0x00, flag=1. Op 0xC -> result=0, flag=0, done pulses.
REQ-026 BCD a=0xFF -> ready low 8 cycles, then bcd=0x255 with one done pulse, result/flag unchanged. Start with ADD during CONV is ignored. BCD a=0x00 -> 0x000; a=0x64 -> 0x100.
REQ-027 BCD a=0xC8 with reset_n low at iteration 4 -> all outputs 0, ready=1, no done. A subsequent BCD a=0x09 -> bcd=0x009.
